// File: rtl/lcd_nibble_receiver.sv
// Purpose: receiving end of a 4-bit character-LCD bus. Registers E/RS/RW/SF/DB,
// checks the power-on init nibble sequence (3,3,3,2), pairs high/low nibbles
// into bytes, tracks the DDRAM address and flags timing/protocol violations.
// Ports:
//   Clock, Reset            - clock, synchronous active-high reset
//   iLCD_*                  - LCD bus inputs (E, RS, RW, StrataFlash ctrl, DB[7:4])
//   oByte/oRS/oValid        - last assembled byte, its RS, one-cycle new-byte strobe
//   oAddress                - current DDRAM address
//   oInitDone               - init nibble sequence completed
//   oTimingError            - sticky pulse-width / gap violation
//   oProtocolError          - sticky bad init nibble / RW=1 / SF=0 at E fall
module lcd_nibble_receiver #(
    parameter int unsigned MIN_EN_CYCLES  = 12,
    parameter int unsigned MIN_NIBBLE_GAP = 50,
    parameter int unsigned MIN_BYTE_GAP   = 2000,
    parameter int unsigned CNT_W          = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic       iLCD_StrataFlashControl,
    input  logic [3:0] iLCD_Data,
    output logic [7:0] oByte,
    output logic       oRS,
    output logic       oValid,
    output logic [6:0] oAddress,
    output logic       oInitDone,
    output logic       oTimingError,
    output logic       oProtocolError
);

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned ADDR_W = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_HI, S_LO
    } state_t;

    state_t             state_q;
    // Stage 1: input register; stage 2: stage 1 delayed (cycle N-1 view)
    logic               e1_q, e2_q;
    logic               rs1_q, rs2_q;
    logic               rw1_q, rw2_q;
    logic               sf1_q, sf2_q;
    logic [NIB_W-1:0]   d1_q, d2_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic [CNT_W-1:0]   gcnt_q;
    logic [NIB_W-1:0]   hi_nib_q;
    logic               byte_seen_q;

    logic               fall_c;
    logic               rise_c;
    logic               bus_ok_c;
    logic [NIB_W-1:0]   init_exp_c;
    logic [ADDR_W-1:0]  addr_next_c;

    assign fall_c   = e2_q & ~e1_q;
    assign rise_c   = e1_q & ~e2_q;
    assign bus_ok_c = ~rw2_q & sf2_q;

    // Nibble expected in the current init state
    always_comb begin
        init_exp_c = NIB_W'(3);
        if (state_q == S_INIT3) init_exp_c = NIB_W'(2);
    end

    // DDRAM address following the byte just emitted
    always_comb begin
        addr_next_c = oAddress;
        if (oRS) begin
            if (oAddress == ADDR_W'(7'h27))      addr_next_c = ADDR_W'(7'h40);
            else if (oAddress == ADDR_W'(7'h67)) addr_next_c = ADDR_W'(7'h00);
            else                                 addr_next_c = oAddress + ADDR_W'(1);
        end else if (oByte[7]) begin
            addr_next_c = oByte[6:0];
        end else if (oByte == 8'h01 || oByte == 8'h02) begin
            addr_next_c = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_INIT0;
            e1_q           <= 1'b0;
            e2_q           <= 1'b0;
            rs1_q          <= 1'b0;
            rs2_q          <= 1'b0;
            rw1_q          <= 1'b0;
            rw2_q          <= 1'b0;
            sf1_q          <= 1'b0;
            sf2_q          <= 1'b0;
            d1_q           <= '0;
            d2_q           <= '0;
            wcnt_q         <= '0;
            gcnt_q         <= CNT_MAX;
            hi_nib_q       <= '0;
            byte_seen_q    <= 1'b0;
            oByte          <= '0;
            oRS            <= 1'b0;
            oValid         <= 1'b0;
            oAddress       <= '0;
            oInitDone      <= 1'b0;
            oTimingError   <= 1'b0;
            oProtocolError <= 1'b0;
        end else begin
            e1_q  <= iLCD_Enabled;
            rs1_q <= iLCD_RegisterSelect;
            rw1_q <= iLCD_ReadWrite;
            sf1_q <= iLCD_StrataFlashControl;
            d1_q  <= iLCD_Data;
            e2_q  <= e1_q;
            rs2_q <= rs1_q;
            rw2_q <= rw1_q;
            sf2_q <= sf1_q;
            d2_q  <= d1_q;

            oValid <= 1'b0;

            // wcnt holds the number of E-high cycles when the fall is seen
            if (rise_c)                        wcnt_q <= CNT_W'(1);
            else if (e1_q && wcnt_q != CNT_MAX) wcnt_q <= wcnt_q + CNT_W'(1);

            // gcnt holds clocks elapsed since the last fall when the next rise is seen
            if (fall_c)                  gcnt_q <= CNT_W'(1);
            else if (gcnt_q != CNT_MAX)  gcnt_q <= gcnt_q + CNT_W'(1);

            if (fall_c && wcnt_q < CNT_W'(MIN_EN_CYCLES))
                oTimingError <= 1'b1;
            if (rise_c && state_q == S_LO && gcnt_q < CNT_W'(MIN_NIBBLE_GAP))
                oTimingError <= 1'b1;
            if (rise_c && state_q == S_HI && byte_seen_q && gcnt_q < CNT_W'(MIN_BYTE_GAP))
                oTimingError <= 1'b1;

            if (fall_c) begin
                if (!bus_ok_c) begin
                    oProtocolError <= 1'b1;
                end else begin
                    case (state_q)
                        S_INIT0, S_INIT1, S_INIT2, S_INIT3: begin
                            if (d2_q != init_exp_c) begin
                                oProtocolError <= 1'b1;
                                state_q        <= S_INIT0;
                            end else if (state_q == S_INIT3) begin
                                oInitDone <= 1'b1;
                                state_q   <= S_HI;
                            end else begin
                                state_q <= state_t'(state_q + 3'd1);
                            end
                        end
                        S_HI: begin
                            hi_nib_q <= d2_q;
                            state_q  <= S_LO;
                        end
                        S_LO: begin
                            oByte       <= {hi_nib_q, d2_q};
                            oRS         <= rs2_q;
                            oValid      <= 1'b1;
                            byte_seen_q <= 1'b1;
                            state_q     <= S_HI;
                        end
                        default: state_q <= S_INIT0;
                    endcase
                end
            end

            if (oValid) oAddress <= addr_next_c;
        end
    end

endmodule
